// File: rtl/regfile_operand_fetch_pkg.sv
// regfile_operand_fetch_pkg: shared widths, types and flow states for the operand-fetch stage
package regfile_operand_fetch_pkg;
    localparam int DATA_W = 4;
    localparam int NREGS = 8;
    localparam int ADDR_W = $clog2(NREGS);
    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} flow_t;
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: register file with two async read ports, one sync write port, R0 hardwired to zero
module regfile_2r1w
    import regfile_operand_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1_i,
    input  logic [ADDR_W-1:0] ra2_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wa_i,
    input  logic [DATA_W-1:0] wd_i
);
    data_t regs_q [NREGS];
    // write port; writes to R0 are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we_i && wa_i != '0) begin
            regs_q[wa_i] <= wd_i;
        end
    end
    assign rd1_o = (ra1_i == '0) ? '0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == '0) ? '0 : regs_q[ra2_i];
endmodule

// File: rtl/regfile_operand_fetch.sv
// regfile_operand_fetch: operand fetch with write-back bypass, pending-write scoreboard and one-entry output register
module regfile_operand_fetch
    import regfile_operand_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_use_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] opa,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              sel,
    output logic [ADDR_W-1:0] out_rd,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);
    flow_t            state_q;
    logic [NREGS-1:0] pend_q, pend_d;
    data_t            rf_rd1, rf_rd2, rs1_val, rs2_val;
    data_t            opa_q, a_q, b_q;
    logic             sel_q;
    reg_addr_t        rd_q;
    logic             hit1, hit2, hazard, accept;

    regfile_2r1w u_rf (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (in_rs1),
        .ra2_i (in_rs2),
        .rd1_o (rf_rd1),
        .rd2_o (rf_rd2),
        .we_i  (wr_en),
        .wa_i  (wr_addr),
        .wd_i  (wr_data)
    );

    assign hit1      = wr_en && wr_addr == in_rs1;
    assign hit2      = wr_en && wr_addr == in_rs2;
    assign hazard    = (pend_q[in_rs1] && !hit1) || (!in_use_imm && pend_q[in_rs2] && !hit2);
    assign out_valid = state_q == FULL;
    assign in_ready  = !hazard && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign rs1_val   = (hit1 && in_rs1 != '0) ? wr_data : rf_rd1;
    assign rs2_val   = (hit2 && in_rs2 != '0) ? wr_data : rf_rd2;
    assign opa       = opa_q;
    assign a         = a_q;
    assign b         = b_q;
    assign sel       = sel_q;
    assign out_rd    = rd_q;

    // scoreboard next state: write-back clears, a new destination sets and wins, R0 never pends
    always_comb begin
        pend_d = pend_q;
        if (wr_en) pend_d[wr_addr] = 1'b0;
        if (accept) pend_d[in_rd] = 1'b1;
        pend_d[0] = 1'b0;
    end

    // scoreboard register
    always_ff @(posedge clk) begin
        pend_q <= rst ? '0 : pend_d;
    end

    // output bundle and EMPTY/FULL flow state; holds while full and not consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            opa_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= 1'b0;
            rd_q    <= '0;
        end else if (accept) begin
            state_q <= FULL;
            opa_q   <= rs1_val;
            a_q     <= rs2_val;
            b_q     <= in_imm;
            sel_q   <= in_use_imm;
            rd_q    <= in_rd;
        end else if (out_ready) begin
            state_q <= EMPTY;
        end
    end
endmodule

// File: tb/tb_regfile_operand_fetch.sv
// tb_regfile_operand_fetch: scoreboard-driven checks of fetch, bypass, stalls, backpressure and reset
module tb_regfile_operand_fetch;
    import regfile_operand_fetch_pkg::*;

    typedef struct packed {
        logic [3:0] opa;
        logic [3:0] a;
        logic [3:0] b;
        logic       sel;
        logic [2:0] rd;
    } bundle_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic       in_valid = 1'b0, in_use_imm = 1'b0, out_ready = 1'b0, wr_en = 1'b0;
    logic [2:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0, wr_addr = '0;
    logic [3:0] in_imm = '0, wr_data = '0;
    logic       in_ready, out_valid, sel;
    logic [3:0] opa, a, b;
    logic [2:0] out_rd;
    bundle_t    obs;

    bundle_t    q[$];
    logic [3:0] mreg [8];
    logic [7:0] mpend = '0;
    int         total = 0, passed = 0;

    regfile_operand_fetch dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .out_valid(out_valid), .out_ready(out_ready),
        .opa(opa), .a(a), .b(b), .sel(sel), .out_rd(out_rd),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    assign obs = {opa, a, b, sel, out_rd};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    function automatic logic [3:0] mop(input logic [2:0] rs);
        return (rs == 3'd0) ? 4'h0 : (wr_en && wr_addr == rs) ? wr_data : mreg[rs];
    endfunction

    function automatic logic mready();
        logic h1, h2;
        h1 = mpend[in_rs1] && !(wr_en && wr_addr == in_rs1);
        h2 = !in_use_imm && mpend[in_rs2] && !(wr_en && wr_addr == in_rs2);
        return !(h1 || h2) && (q.size() == 0 || out_ready);
    endfunction

    task automatic drive(input logic v, input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] rd,
                         input logic [3:0] imm, input logic ui, input logic ordy,
                         input logic we, input logic [2:0] wa, input logic [3:0] wd);
        in_valid = v; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_imm = imm; in_use_imm = ui;
        out_ready = ordy; wr_en = we; wr_addr = wa; wr_data = wd;
        #1;
    endtask

    task automatic tick();
        logic    acc, cons;
        bundle_t e;
        acc  = in_valid && mready();
        cons = q.size() != 0 && out_ready;
        e    = {mop(in_rs1), mop(in_rs2), in_imm, in_use_imm, in_rd};
        @(posedge clk);
        if (rst) begin
            q.delete();
            mpend = '0;
            for (int i = 0; i < 8; i++) mreg[i] = 4'h0;
        end else begin
            if (cons) void'(q.pop_front());
            if (acc) q.push_back(e);
            if (wr_en) mpend[wr_addr] = 1'b0;
            if (acc && in_rd != 3'd0) mpend[in_rd] = 1'b1;
            if (wr_en && wr_addr != 3'd0) mreg[wr_addr] = wr_data;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 1, 2, 3, 4'h5, 0, 1, 1, 3, 4'h9);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
        total++; if (obs !== '0) $display("FAIL reset_bundle: got %h want 0", obs); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_writeback();
        drive(0, 0, 0, 0, 0, 0, 1, 1, 3, 4'h9);
        tick();
        drive(1, 3, 0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        total++; if (out_valid !== 1'b1) $display("FAIL wb_valid: got %b want 1", out_valid); else passed++;
        total++; if ({opa, a, sel} !== {4'h9, 4'h0, 1'b0}) $display("FAIL wb_ops: got opa=%h a=%h sel=%b want 9 0 0", opa, a, sel); else passed++;
        total++; if (q.size() == 0 || obs !== q[0]) $display("FAIL wb_sb: got %h want %h", obs, q.size() ? q[0] : '0); else passed++;
    endtask

    task automatic test_imm();
        drive(1, 3, 5, 0, 4'hC, 1, 1, 0, 0, 0);
        tick();
        total++; if ({b, sel, opa} !== {4'hC, 1'b1, 4'h9}) $display("FAIL imm_ops: got b=%h sel=%b opa=%h want C 1 9", b, sel, opa); else passed++;
        total++; if (q.size() == 0 || obs !== q[0]) $display("FAIL imm_sb: got %h want %h", obs, q.size() ? q[0] : '0); else passed++;
    endtask

    task automatic test_r0();
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 4'hF);
        tick();
        total++; if ({opa, a} !== 8'h00) $display("FAIL r0_bypass: got opa=%h a=%h want 0 0", opa, a); else passed++;
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        total++; if ({opa, a} !== 8'h00) $display("FAIL r0_read: got opa=%h a=%h want 0 0", opa, a); else passed++;
        total++; if (q.size() == 0 || obs !== q[0]) $display("FAIL r0_sb: got %h want %h", obs, q.size() ? q[0] : '0); else passed++;
    endtask

    task automatic test_hazard();
        drive(1, 0, 0, 5, 0, 0, 1, 0, 0, 0);
        tick();
        drive(1, 5, 0, 0, 4'h1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            total++; if (in_ready !== 1'b0) $display("FAIL haz_stall%0d: got %b want 0", i, in_ready); else passed++;
            tick();
        end
        total++; if (out_valid !== 1'b0) $display("FAIL haz_drained: got %b want 0", out_valid); else passed++;
        drive(1, 5, 0, 0, 4'h1, 1, 1, 1, 5, 4'h7);
        total++; if (in_ready !== 1'b1) $display("FAIL haz_release: got %b want 1", in_ready); else passed++;
        tick();
        total++; if ({out_valid, opa} !== {1'b1, 4'h7}) $display("FAIL haz_bypass: got v=%b opa=%h want 1 7", out_valid, opa); else passed++;
        total++; if (q.size() == 0 || obs !== q[0]) $display("FAIL haz_sb: got %h want %h", obs, q.size() ? q[0] : '0); else passed++;
        drive(1, 5, 0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        total++; if (opa !== 4'h7) $display("FAIL haz_after: got %h want 7", opa); else passed++;
    endtask

    task automatic test_backpressure();
        bundle_t held;
        drive(1, 3, 0, 0, 4'h2, 1, 1, 0, 0, 0);
        tick();
        held = q.size() ? q[0] : '0;
        drive(1, 5, 0, 0, 4'hA, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            total++; if (in_ready !== 1'b0) $display("FAIL bp_ready%0d: got %b want 0", i, in_ready); else passed++;
            total++; if ({out_valid, obs} !== {1'b1, held}) $display("FAIL bp_hold%0d: got v=%b %h want 1 %h", i, out_valid, obs, held); else passed++;
            tick();
        end
        total++; if (opa !== 4'h9) $display("FAIL bp_held_opa: got %h want 9", opa); else passed++;
        drive(1, 5, 0, 0, 4'hA, 1, 1, 0, 0, 0);
        total++; if (in_ready !== 1'b1) $display("FAIL bp_release: got %b want 1", in_ready); else passed++;
        tick();
        total++; if ({out_valid, opa, b} !== {1'b1, 4'h7, 4'hA}) $display("FAIL bp_new: got v=%b opa=%h b=%h want 1 7 A", out_valid, opa, b); else passed++;
        for (int i = 0; i < 3; i++) begin
            drive(1, 3, 0, 0, 4'(i + 3), 1, 1, 0, 0, 0);
            tick();
            total++; if ({out_valid, b} !== {1'b1, 4'(i + 3)}) $display("FAIL b2b%0d: got v=%b b=%h want 1 %h", i, out_valid, b, 4'(i + 3)); else passed++;
            total++; if (q.size() == 0 || obs !== q[0]) $display("FAIL b2b_sb%0d: got %h want %h", i, obs, q.size() ? q[0] : '0); else passed++;
        end
    endtask

    task automatic test_set_wins();
        drive(1, 0, 0, 2, 0, 0, 1, 1, 2, 4'h3);
        tick();
        drive(1, 2, 0, 0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            total++; if (in_ready !== 1'b0) $display("FAIL sw_stall%0d: got %b want 0", i, in_ready); else passed++;
            tick();
        end
        drive(1, 2, 0, 0, 0, 1, 1, 1, 2, 4'h6);
        total++; if (in_ready !== 1'b1) $display("FAIL sw_release: got %b want 1", in_ready); else passed++;
        tick();
        total++; if (opa !== 4'h6) $display("FAIL sw_opa: got %h want 6", opa); else passed++;
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 0, 4, 0, 0, 1, 1, 3, 4'h5);
        tick();
        drive(1, 4, 0, 0, 0, 1, 0, 0, 0, 0);
        total++; if ({out_valid, in_ready} !== 2'b10) $display("FAIL rm_pre: got v=%b rdy=%b want 1 0", out_valid, in_ready); else passed++;
        tick();
        rst = 1'b1;
        drive(1, 4, 0, 0, 0, 1, 0, 1, 3, 4'h5);
        tick();
        rst = 1'b0;
        drive(1, 4, 0, 0, 0, 1, 0, 0, 0, 0);
        total++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL rm_post: got v=%b rdy=%b want 0 1", out_valid, in_ready); else passed++;
        total++; if (obs !== '0) $display("FAIL rm_bundle: got %h want 0", obs); else passed++;
        drive(1, 3, 3, 0, 0, 0, 1, 0, 0, 0);
        tick();
        total++; if ({out_valid, opa, a} !== {1'b1, 8'h00}) $display("FAIL rm_r3: got v=%b opa=%h a=%h want 1 0 0", out_valid, opa, a); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mreg[i] = 4'h0;
        test_reset();
        test_writeback();
        test_imm();
        test_r0();
        test_hazard();
        test_backpressure();
        test_set_wins();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
